wb_serializer_fifo: RTL and testbench
=====================================

Name: wb_serializer_fifo

Overview:
Wishbone slave that buffers multi-symbol words in a FIFO and shifts them out MSB-first on a single serial line.
- Each word holds SYM_PER_WORD symbols of SYM_W bits each (k-flag + payload; k=1 marks a kcode symbol).
- Supersedes the single-shot serializer: adds configurable symbol count and width, FIFO buffering, bit-rate divider, back-to-back streaming, and status/control registers.
- Sits between the CPU Wishbone bus and the link PHY pin.

Parameters:
SYM_W, 9, bits per symbol (MSB = k flag)
SYM_PER_WORD, 3, symbols per Wishbone word; SYM_W*SYM_PER_WORD must be <= 32 (elaboration $error otherwise)
FIFO_DEPTH, 4, words buffered; power of 2, >= 2
CLKS_PER_BIT, 1, clock cycles per serial bit; >= 1

Ports:
CLK_I  in  1  clock; everything is on rising edge
RST_I  in  1  asynchronous, active-high reset
CYC_I  in  1  bus cycle
STB_I  in  1  strobe
WE_I  in  1  write enable
ADR_I  in  32  address; only ADR_I[1:0] decoded
DAT_I  in  32  write data
DAT_O  out  32  read data
ACK_O  out  1  acknowledge
ERR_O  out  1  error
data_o  out  1  serial output
sym_strobe_o  out  1  one-cycle pulse on the first clock of each transmitted symbol
busy_o  out  1  high while a word is being shifted

Behaviour:
- Reset (async): FIFO empty, FSM IDLE, data_o=0, sym_strobe_o=0, busy_o=0, ACK_O=0, ERR_O=0, DAT_O=0, ctrl.enable=1, overflow=0.
- Register map, ADR_I[1:0]:
  - 0 DATA: write-only; pushes DAT_I[SYM_W*SYM_PER_WORD-1:0]; upper bits ignored.
  - 1 STATUS: read-only; [0]=empty, [1]=full, [2]=busy, [3]=overflow (sticky), [15:8]=FIFO count, others 0.
  - 2 CTRL: R/W; [0]=enable; [1]=write-1-clears overflow, always reads 0.
  - 3: unmapped.
- Handshake:
  - ACK_O/ERR_O are registered and asserted exactly one cycle after the edge sampling CYC_I&STB_I with both low.
  - Each is a single-cycle pulse; never both high.
  - Side effects (push, CTRL update) occur at the sampling edge. DAT_O is valid while ACK_O is high.
- Errors (ERR_O instead of ACK_O; no side effect):
  - write DATA when full (word dropped, overflow<=1);
  - read DATA; write STATUS; any access to address 3.
- Full/empty: full is evaluated before any same-cycle pop, so a write while full errors even if a pop occurs that edge. Simultaneous push and pop while not full leaves the count unchanged.
- FSM (IDLE, LOAD, SHIFT):
  - IDLE -> LOAD when enable && !empty; LOAD pops the head word into the shift register.
  - LOAD -> SHIFT. In SHIFT each bit is held CLKS_PER_BIT cycles.
  - Order: symbol 0 = bits [SYM_W*SYM_PER_WORD-1 -: SYM_W], each symbol MSB (k flag) first.
  - After the last bit: LOAD if enable && !empty (zero-gap streaming), else IDLE.
- Latency: with FSM in IDLE, the first bit drives data_o 2 cycles after the push edge. Word duration = SYM_W*SYM_PER_WORD*CLKS_PER_BIT cycles.
- busy_o is high in LOAD and SHIFT.
- data_o in IDLE = 0.
- Clearing enable mid-word: the current word completes, then the FSM goes IDLE; FIFO contents are retained.
- Reset mid-word: immediate abort; FIFO flushed; outputs return to reset values.
- CYC_I deassertion only terminates bus handshakes; it does not affect serialization.

Optional Feature:
WB_SERIALIZER_IDLE_KCODE_EN
- Defined: while IDLE, data_o continuously transmits the idle symbol IDLE_KCODE ({1'b1, 8'hBC} for SYM_W=9, padded/truncated to SYM_W), with sym_strobe_o pulsing per symbol. A pending word starts only at an idle-symbol boundary, so latency may grow by up to SYM_W*CLKS_PER_BIT cycles.
- Undefined: data_o=0 and sym_strobe_o=0 in IDLE.

Decomposition:
- Package WBSerializer holds the shared definitions:
  - address constants ADR_DATA=0, ADR_STATUS=1, ADR_CTRL=2;
  - STATUS/CTRL bit indices;
  - IDLE_KCODE;
  - FSM state enum.
- Sub-module ser_fifo: synchronous FIFO, parameters WIDTH and DEPTH; ports push, pop, din, dout, full, empty, count.

Test Plan:
- Defaults: write DATA 32'h06F0_AAAA ({1,BC},{0,55},{0,AA}) -> ACK after 1 cycle; from 2 cycles later data_o = 110111100_001010101_010101010 over 27 cycles; sym_strobe_o pulses at cycles 0, 9, 18.
- Five consecutive DATA writes while enable=0 -> writes 1-4 ACK, write 5 ERR; STATUS reads 32'h0000_040A (count=4, full, overflow). Set enable=1 -> 4 words stream back-to-back with no gap; STATUS ends at 32'h0000_0009.
- CLKS_PER_BIT=3, one word -> each bit held exactly 3 cycles; busy_o high for 82 cycles (LOAD + 81).
- Read DATA, write STATUS, and access address 3 -> ERR_O pulse each time; no FIFO or CTRL change.
- Assert RST_I asynchronously at bit 10 of a word with 2 words queued -> data_o and busy_o go 0 immediately; STATUS after release = 32'h0000_0001.
- WB_SERIALIZER_IDLE_KCODE_EN defined, no writes -> data_o repeats 110111100 with sym_strobe_o every 9 cycles; a push mid-symbol starts data at the next symbol boundary.

Source files
------------

// File: rtl/wb_serializer_fifo_pkg.sv
// Shared definitions for the Wishbone FIFO serializer: register addresses,
// STATUS/CTRL bit positions, the idle K-code and the serializer FSM states.
package wb_serializer_fifo_pkg;

  localparam logic [1:0] ADR_DATA   = 2'd0;
  localparam logic [1:0] ADR_STATUS = 2'd1;
  localparam logic [1:0] ADR_CTRL   = 2'd2;

  localparam int unsigned ST_EMPTY_BIT = 0;
  localparam int unsigned ST_FULL_BIT  = 1;
  localparam int unsigned ST_BUSY_BIT  = 2;
  localparam int unsigned ST_OVF_BIT   = 3;
  localparam int unsigned ST_CNT_LSB   = 8;

  localparam int unsigned CTRL_EN_BIT      = 0;
  localparam int unsigned CTRL_OVF_CLR_BIT = 1;

  // K-flag set, comma character 0xBC
  localparam logic [8:0] IDLE_KCODE = {1'b1, 8'hBC};

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_SHIFT
  } ser_state_e;

  // Counter width that stays legal when the count range collapses to 1
  function automatic int unsigned clog2_min1(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/wb_serializer_fifo_if.sv
// Wishbone classic slave bus bundle for the FIFO serializer.
interface wb_serializer_fifo_if;
  logic        CYC_I;
  logic        STB_I;
  logic        WE_I;
  logic [31:0] ADR_I;
  logic [31:0] DAT_I;
  logic [31:0] DAT_O;
  logic        ACK_O;
  logic        ERR_O;

  modport slave  (input  CYC_I, STB_I, WE_I, ADR_I, DAT_I,
                  output DAT_O, ACK_O, ERR_O);
  modport master (output CYC_I, STB_I, WE_I, ADR_I, DAT_I,
                  input  DAT_O, ACK_O, ERR_O);
endinterface

// File: rtl/wb_serializer_fifo_ser_fifo.sv
// Show-ahead synchronous FIFO: dout always presents the head word.
// Push when full and pop when empty are ignored.
module ser_fifo #(
  parameter int unsigned WIDTH = 27,
  parameter int unsigned DEPTH = 4
) (
  input  logic                     CLK_I,
  input  logic                     RST_I,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         din,
  output logic [WIDTH-1:0]         dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = mem[rd_ptr];

  // Storage write
  always_ff @(posedge CLK_I) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  // Pointers and occupancy; simultaneous push and pop leave count unchanged
  always_ff @(posedge CLK_I or posedge RST_I) begin
    if (RST_I) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end
endmodule

// File: rtl/wb_serializer_fifo.sv
// Wishbone slave that queues multi-symbol words and shifts them out MSB-first.
// Optional WB_SERIALIZER_IDLE_KCODE_EN: send IDLE_KCODE continuously while idle.
module wb_serializer_fifo
  import wb_serializer_fifo_pkg::*;
#(
  parameter int unsigned SYM_W        = 9,
  parameter int unsigned SYM_PER_WORD = 3,
  parameter int unsigned FIFO_DEPTH   = 4,
  parameter int unsigned CLKS_PER_BIT = 1
) (
  input  logic                 CLK_I,
  input  logic                 RST_I,
  wb_serializer_fifo_if.slave  wb,
  output logic                 data_o,
  output logic                 sym_strobe_o,
  output logic                 busy_o
);
  localparam int unsigned WORD_W = SYM_W * SYM_PER_WORD;
  localparam int unsigned CNT_W  = $clog2(FIFO_DEPTH) + 1;
  localparam int unsigned DIV_W  = clog2_min1(CLKS_PER_BIT);
  localparam int unsigned SB_W   = clog2_min1(SYM_W);
  localparam int unsigned SI_W   = clog2_min1(SYM_PER_WORD);

  if (WORD_W > 32) begin : g_chk_width
    $error("SYM_W*SYM_PER_WORD must be <= 32");
  end
  if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_chk_depth
    $error("FIFO_DEPTH must be a power of 2 and >= 2");
  end
  if (CLKS_PER_BIT < 1 || SYM_W < 2) begin : g_chk_misc
    $error("CLKS_PER_BIT must be >= 1 and SYM_W >= 2");
  end

  ser_state_e        state, state_nx;
  logic              enable, overflow;
  logic              ack_q, err_q;
  logic [31:0]       dat_q, rd_data, status;
  logic              req, acc_ok, push, pop;
  logic [WORD_W-1:0] fifo_dout, shreg;
  logic              fifo_full, fifo_empty;
  logic [CNT_W-1:0]  fifo_count;
  logic [DIV_W-1:0]  div_cnt;
  logic [SB_W-1:0]   sym_bit;
  logic [SI_W-1:0]   sym_idx;
  logic              bit_end, sym_end, word_end, start_ok, advance;
  logic              unused_bits;

  assign wb.ACK_O    = ack_q;
  assign wb.ERR_O    = err_q;
  assign wb.DAT_O    = dat_q;
  assign busy_o      = (state != S_IDLE);
  assign unused_bits = ^{wb.ADR_I[31:2], wb.DAT_I};

  // A new request is only taken while no response is outstanding
  assign req  = wb.CYC_I && wb.STB_I && !ack_q && !err_q;
  assign push = req && wb.WE_I && (wb.ADR_I[1:0] == ADR_DATA) && !fifo_full;

  ser_fifo #(.WIDTH(WORD_W), .DEPTH(FIFO_DEPTH)) u_fifo (
    .CLK_I (CLK_I),
    .RST_I (RST_I),
    .push  (push),
    .pop   (pop),
    .din   (wb.DAT_I[WORD_W-1:0]),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  // Register decode: legality of the access and read data
  always_comb begin
    status                        = '0;
    status[ST_EMPTY_BIT]          = fifo_empty;
    status[ST_FULL_BIT]           = fifo_full;
    status[ST_BUSY_BIT]           = busy_o;
    status[ST_OVF_BIT]            = overflow;
    status[ST_CNT_LSB +: 8]       = 8'(fifo_count);
    acc_ok  = 1'b0;
    rd_data = '0;
    case (wb.ADR_I[1:0])
      ADR_DATA:   acc_ok = wb.WE_I && !fifo_full;
      ADR_STATUS: begin
        acc_ok  = !wb.WE_I;
        rd_data = status;
      end
      ADR_CTRL:   begin
        acc_ok               = 1'b1;
        rd_data[CTRL_EN_BIT] = enable;
      end
      default:    acc_ok = 1'b0;
    endcase
  end

  // Bus response and control/status register updates
  always_ff @(posedge CLK_I or posedge RST_I) begin
    if (RST_I) begin
      ack_q    <= 1'b0;
      err_q    <= 1'b0;
      dat_q    <= '0;
      enable   <= 1'b1;
      overflow <= 1'b0;
    end else begin
      ack_q <= req && acc_ok;
      err_q <= req && !acc_ok;
      dat_q <= (req && acc_ok && !wb.WE_I) ? rd_data : '0;
      if (req && wb.WE_I && (wb.ADR_I[1:0] == ADR_DATA) && fifo_full)
        overflow <= 1'b1;
      if (req && wb.WE_I && (wb.ADR_I[1:0] == ADR_CTRL)) begin
        enable <= wb.DAT_I[CTRL_EN_BIT];
        if (wb.DAT_I[CTRL_OVF_CLR_BIT]) overflow <= 1'b0;
      end
    end
  end

  assign bit_end  = (div_cnt == DIV_W'(CLKS_PER_BIT - 1));
  assign sym_end  = bit_end && (sym_bit == SB_W'(SYM_W - 1));
  assign word_end = sym_end && (sym_idx == SI_W'(SYM_PER_WORD - 1));
  assign start_ok = enable && !fifo_empty;

`ifdef WB_SERIALIZER_IDLE_KCODE_EN
  localparam logic [SYM_W-1:0] KCODE = SYM_W'(IDLE_KCODE);
  logic             idle_run;
  logic [SYM_W-1:0] kc_shift;

  // Holds the idle stream off until the first clock after reset release
  always_ff @(posedge CLK_I or posedge RST_I) begin
    if (RST_I) idle_run <= 1'b0;
    else       idle_run <= 1'b1;
  end
  assign advance = (state == S_SHIFT) || (state == S_IDLE && idle_run);
`else
  assign advance = (state == S_SHIFT);
`endif

  // FSM state register
  always_ff @(posedge CLK_I or posedge RST_I) begin
    if (RST_I) state <= S_IDLE;
    else       state <= state_nx;
  end

  // FSM next state; LOAD pops the head word, so it is the only pop source
  always_comb begin
    state_nx = state;
    pop      = 1'b0;
    case (state)
`ifdef WB_SERIALIZER_IDLE_KCODE_EN
      S_IDLE:  if (start_ok && idle_run && sym_end) state_nx = S_LOAD;
`else
      S_IDLE:  if (start_ok) state_nx = S_LOAD;
`endif
      S_LOAD:  begin
        pop      = 1'b1;
        state_nx = S_SHIFT;
      end
      S_SHIFT: if (word_end) state_nx = start_ok ? S_LOAD : S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  // Shift register and bit/symbol timing counters
  always_ff @(posedge CLK_I or posedge RST_I) begin
    if (RST_I) begin
      shreg   <= '0;
      div_cnt <= '0;
      sym_bit <= '0;
      sym_idx <= '0;
    end else if (state == S_LOAD) begin
      shreg   <= fifo_dout;
      div_cnt <= '0;
      sym_bit <= '0;
      sym_idx <= '0;
    end else if (advance) begin
      if (bit_end) begin
        div_cnt <= '0;
        if (state == S_SHIFT) shreg <= {shreg[WORD_W-2:0], 1'b0};
        if (sym_end) begin
          sym_bit <= '0;
          if (state == S_SHIFT) sym_idx <= word_end ? '0 : sym_idx + 1'b1;
        end else begin
          sym_bit <= sym_bit + 1'b1;
        end
      end else begin
        div_cnt <= div_cnt + 1'b1;
      end
    end else begin
      div_cnt <= '0;
      sym_bit <= '0;
      sym_idx <= '0;
    end
  end

  // Serial line and symbol strobe
  always_comb begin
    data_o       = 1'b0;
    sym_strobe_o = 1'b0;
`ifdef WB_SERIALIZER_IDLE_KCODE_EN
    kc_shift     = KCODE << sym_bit;
`endif
    if (state == S_SHIFT) begin
      data_o       = shreg[WORD_W-1];
      sym_strobe_o = (div_cnt == '0) && (sym_bit == '0);
    end
`ifdef WB_SERIALIZER_IDLE_KCODE_EN
    else if (state == S_IDLE && idle_run) begin
      data_o       = kc_shift[SYM_W-1];
      sym_strobe_o = (div_cnt == '0) && (sym_bit == '0);
    end
`endif
  end
endmodule

// File: tb/tb_wb_serializer_fifo.sv
// Directed bench for wb_serializer_fifo: register access, streaming, errors,
// slow bit rate (second instance, CLKS_PER_BIT=3) and async reset abort.
module tb_wb_serializer_fifo;
  import wb_serializer_fifo_pkg::*;

  logic CLK_I = 1'b0;
  logic RST_I = 1'b1;
  logic data_o, sym_strobe_o, busy_o;
  logic data2, strobe2, busy2;
  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;
  logic [31:0] words [5] = '{32'hF800_0001, 32'h0123_4567, 32'h07FF_FFFF,
                             32'hA2AA_5555, 32'h0000_0FFF};

  wb_serializer_fifo_if wb ();
  wb_serializer_fifo_if wb2 ();

  always #5 CLK_I = ~CLK_I;

  wb_serializer_fifo #(.SYM_W(9), .SYM_PER_WORD(3), .FIFO_DEPTH(4), .CLKS_PER_BIT(1)) dut (
    .CLK_I        (CLK_I),
    .RST_I        (RST_I),
    .wb           (wb),
    .data_o       (data_o),
    .sym_strobe_o (sym_strobe_o),
    .busy_o       (busy_o)
  );

  wb_serializer_fifo #(.SYM_W(9), .SYM_PER_WORD(3), .FIFO_DEPTH(4), .CLKS_PER_BIT(3)) dut2 (
    .CLK_I        (CLK_I),
    .RST_I        (RST_I),
    .wb           (wb2),
    .data_o       (data2),
    .sym_strobe_o (strobe2),
    .busy_o       (busy2)
  );

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, act, exp);
    end
  endtask

  // One Wishbone transfer on the first instance; response wait is bounded
  task automatic wb_xfer(input logic we, input logic [1:0] adr, input logic [31:0] wdat,
                         output logic ack, output logic err, output logic [31:0] rdat);
    @(negedge CLK_I);
    wb.CYC_I = 1'b1;
    wb.STB_I = 1'b1;
    wb.WE_I  = we;
    wb.ADR_I = {30'b0, adr};
    wb.DAT_I = wdat;
    for (int n = 0; n < 8; n++) begin
      @(posedge CLK_I);
      #1;
      if (wb.ACK_O || wb.ERR_O) break;
    end
    ack  = wb.ACK_O;
    err  = wb.ERR_O;
    rdat = wb.DAT_O;
    check_eq("wb_response", {31'b0, ack | err}, 32'd1);
    wb.CYC_I = 1'b0;
    wb.STB_I = 1'b0;
    wb.WE_I  = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: time limit reached, required finish before it");
    $fatal(1, "watchdog");
  end

  initial begin
    logic        ack, err, gap;
    logic [31:0] rd;
    logic [4:0]  acks, errs;
    logic [26:0] obs, ostb;
    logic [17:0] kobs, kstb;
    int          bcnt, bad, idx, n_busy;

    wb.CYC_I = 1'b0;  wb.STB_I = 1'b0;  wb.WE_I = 1'b0;  wb.ADR_I = '0;  wb.DAT_I = '0;
    wb2.CYC_I = 1'b0; wb2.STB_I = 1'b0; wb2.WE_I = 1'b0; wb2.ADR_I = '0; wb2.DAT_I = '0;
    #2;
    check_eq("reset_outputs", {28'b0, data_o, sym_strobe_o, busy_o, wb.ACK_O}, 32'd0);
    check_eq("reset_err", {31'b0, wb.ERR_O}, 32'd0);
    check_eq("reset_dat", wb.DAT_O, 32'd0);
    @(negedge CLK_I);
    @(negedge CLK_I);
    RST_I = 1'b0;
    wb_xfer(1'b0, ADR_STATUS, 32'd0, ack, err, rd);
    check_eq("reset_status", rd, 32'h0000_0001);
    wb_xfer(1'b0, ADR_CTRL, 32'd0, ack, err, rd);
    check_eq("reset_ctrl", rd, 32'h0000_0001);

`ifdef WB_SERIALIZER_IDLE_KCODE_EN
    idx = 0;
    for (int n = 0; n < 40; n++) begin
      @(negedge CLK_I);
      if (sym_strobe_o) begin idx = 1; break; end
    end
    check_eq("kc_strobe_found", idx, 1);
    kobs[17] = data_o;
    kstb[17] = sym_strobe_o;
    for (int i = 1; i < 18; i++) begin
      @(negedge CLK_I);
      kobs[17-i] = data_o;
      kstb[17-i] = sym_strobe_o;
    end
    check_eq("kc_bits", kobs, 18'b110111100_110111100);
    check_eq("kc_strobes", kstb, 18'b100000000_100000000);
    repeat (3) @(negedge CLK_I);
    wb_xfer(1'b1, ADR_DATA, 32'h06F0_AAAA, ack, err, rd);
    n_busy = -1;
    for (int n = 0; n < 30; n++) begin
      @(negedge CLK_I);
      if (busy_o) begin n_busy = n; break; end
    end
    check_eq("kc_load_at_boundary", n_busy, 32'd5);
    for (int i = 0; i < 27; i++) begin
      @(negedge CLK_I);
      obs[26-i] = data_o;
    end
    check_eq("kc_word_bits", obs, 27'b110111100_001010101_010101010);
`else
    // Single word at default settings
    wb_xfer(1'b1, ADR_DATA, 32'h06F0_AAAA, ack, err, rd);
    check_eq("t1_ack", {30'b0, err, ack}, 32'd1);
    @(posedge CLK_I);
    #1;
    check_eq("t1_ack_pulse", {30'b0, wb.ERR_O, wb.ACK_O}, 32'd0);
    check_eq("t1_load_cycle", {30'b0, busy_o, data_o}, 32'd2);
    @(negedge CLK_I);
    for (int i = 0; i < 27; i++) begin
      @(negedge CLK_I);
      obs[26-i]  = data_o;
      ostb[26-i] = sym_strobe_o;
    end
    check_eq("t1_bits", obs, 27'b110111100_001010101_010101010);
    check_eq("t1_strobes", ostb, 27'b100000000_100000000_100000000);
    @(negedge CLK_I);
    check_eq("t1_idle_after", {29'b0, busy_o, data_o, sym_strobe_o}, 32'd0);

    // Fill while disabled, overflow, then stream
    wb_xfer(1'b1, ADR_CTRL, 32'd0, ack, err, rd);
    for (int w = 0; w < 5; w++) begin
      wb_xfer(1'b1, ADR_DATA, words[w], ack, err, rd);
      acks[w] = ack;
      errs[w] = err;
    end
    check_eq("t2_acks", acks, 5'b01111);
    check_eq("t2_errs", errs, 5'b10000);
    wb_xfer(1'b0, ADR_STATUS, 32'd0, ack, err, rd);
    check_eq("t2_status_full", rd, 32'h0000_040A);
    wb_xfer(1'b1, ADR_CTRL, 32'd1, ack, err, rd);
    repeat (2) @(negedge CLK_I);
    gap = 1'b0;
    for (int w = 0; w < 4; w++) begin
      for (int i = 0; i < 27; i++) begin
        @(negedge CLK_I);
        obs[26-i] = data_o;
        if (!busy_o) gap = 1'b1;
      end
      check_eq($sformatf("t2_word%0d", w), obs, words[w][26:0]);
      if (w < 3) begin
        @(negedge CLK_I);
        if (!busy_o) gap = 1'b1;
      end
    end
    check_eq("t2_busy_gap", gap, 32'd0);
    wb_xfer(1'b0, ADR_STATUS, 32'd0, ack, err, rd);
    check_eq("t2_status_end", rd, 32'h0000_0009);
    wb_xfer(1'b1, ADR_CTRL, 32'd3, ack, err, rd);
    wb_xfer(1'b0, ADR_STATUS, 32'd0, ack, err, rd);
    check_eq("t2_ovf_cleared", rd, 32'h0000_0001);
    wb_xfer(1'b0, ADR_CTRL, 32'd0, ack, err, rd);
    check_eq("t2_ctrl_read", rd, 32'h0000_0001);

    // Illegal accesses
    wb_xfer(1'b0, ADR_DATA, 32'd0, ack, err, rd);            acks[0] = ack; errs[0] = err;
    wb_xfer(1'b1, ADR_STATUS, 32'hFFFF_FFFF, ack, err, rd);  acks[1] = ack; errs[1] = err;
    wb_xfer(1'b0, 2'd3, 32'd0, ack, err, rd);                acks[2] = ack; errs[2] = err;
    wb_xfer(1'b1, 2'd3, 32'd0, ack, err, rd);                acks[3] = ack; errs[3] = err;
    check_eq("t4_errs", errs[3:0], 4'hF);
    check_eq("t4_acks", acks[3:0], 4'h0);
    wb_xfer(1'b0, ADR_STATUS, 32'd0, ack, err, rd);
    check_eq("t4_status", rd, 32'h0000_0001);
    wb_xfer(1'b0, ADR_CTRL, 32'd0, ack, err, rd);
    check_eq("t4_ctrl", rd, 32'h0000_0001);

    // CLKS_PER_BIT=3 instance
    @(negedge CLK_I);
    wb2.CYC_I = 1'b1; wb2.STB_I = 1'b1; wb2.WE_I = 1'b1;
    wb2.ADR_I = 32'd0; wb2.DAT_I = 32'h06F0_AAAA;
    @(posedge CLK_I);
    #1;
    check_eq("t3_ack", {30'b0, wb2.ERR_O, wb2.ACK_O}, 32'd1);
    wb2.CYC_I = 1'b0; wb2.STB_I = 1'b0; wb2.WE_I = 1'b0;
    obs  = 27'b110111100_001010101_010101010;
    bcnt = 0;
    bad  = 0;
    for (int n = 0; n < 200; n++) begin
      @(negedge CLK_I);
      if (busy2) begin
        bcnt++;
        if (bcnt >= 2) begin
          idx = bcnt - 2;
          if (data2 !== obs[26 - idx/3]) bad++;
          if (strobe2 !== ((idx % 27) == 0)) bad++;
        end
      end
    end
    check_eq("t3_busy_cycles", bcnt, 32'd82);
    check_eq("t3_bit_hold_errors", bad, 32'd0);

    // Async reset mid-word with two words still queued
    wb_xfer(1'b1, ADR_CTRL, 32'd0, ack, err, rd);
    for (int w = 0; w < 3; w++) wb_xfer(1'b1, ADR_DATA, 32'h07FF_FFFF, ack, err, rd);
    wb_xfer(1'b1, ADR_CTRL, 32'd1, ack, err, rd);
    repeat (13) @(negedge CLK_I);
    check_eq("t5_before_reset", {30'b0, busy_o, data_o}, 32'd3);
    #1 RST_I = 1'b1;
    #1;
    check_eq("t5_in_reset", {29'b0, busy_o, data_o, sym_strobe_o}, 32'd0);
    @(negedge CLK_I);
    RST_I = 1'b0;
    wb_xfer(1'b0, ADR_STATUS, 32'd0, ack, err, rd);
    check_eq("t5_status", rd, 32'h0000_0001);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
